// File: rtl/inst_mem_loader_pkg.sv
// rtl/inst_mem_loader_pkg.sv - shared constants and FSM encoding for the program loader
package inst_mem_loader_pkg;

  localparam int          BYTES_PER_WORD    = 4;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/inst_mem_loader_byte_word_assembler.sv
// rtl/inst_mem_loader_byte_word_assembler.sv - shifts bytes MSB-first into a word
// o_full flags the load that completes a word; o_word_next is the word including that byte.
module inst_mem_loader_byte_word_assembler
  import inst_mem_loader_pkg::*;
(
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_clear,
  input  logic                          i_load,
  input  logic [7:0]                    i_byte,
  output logic [8*BYTES_PER_WORD-1:0]   o_word_next,
  output logic                          o_full
);

  localparam int WORDW = 8 * BYTES_PER_WORD;
  localparam int CNTW  = $clog2(BYTES_PER_WORD);

  logic [WORDW-1:0] word_q, word_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  assign o_word_next = {word_q[WORDW-9:0], i_byte};
  assign o_full      = i_load && !i_clear && (cnt_q == CNTW'(BYTES_PER_WORD - 1));

  // The counter wraps to zero on the completing byte, so no explicit reset is needed per word.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (i_clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (i_load) begin
      word_d = o_word_next;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - loads a byte stream into instruction memory until the halt word
// i_start restarts a load from any state and outranks a byte or a pending write.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int               NBITS     = 32,
  parameter int               MEM_DEPTH = 256,
  parameter logic [NBITS-1:0] HALT_WORD = NBITS'(HALT_WORD_DEFAULT)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [7:0]       i_byte,
  input  logic             i_byte_valid,
  output logic             o_byte_ready,
  output logic             o_wr_en,
  output logic [NBITS-1:0] o_wr_addr,
  output logic [NBITS-1:0] o_wr_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow
);

  localparam int IDXW = $clog2(MEM_DEPTH);

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             wr_en_q, wr_en_d;
  logic [NBITS-1:0] addr_q, addr_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic                        asm_full;
  logic [8*BYTES_PER_WORD-1:0] asm_word_next;

  assign o_byte_ready = (state_q == ST_RECV);

  inst_mem_loader_byte_word_assembler u_asm (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_start),
    .i_load      (i_byte_valid && o_byte_ready),
    .i_byte      (i_byte),
    .o_word_next (asm_word_next),
    .o_full      (asm_full)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    if (i_start) begin
      state_d = ST_RECV;
      idx_d   = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_RECV: begin
          if (asm_full) begin
            data_d  = NBITS'(asm_word_next);
            addr_d  = NBITS'({idx_q, 2'b00});
            wr_en_d = 1'b1;
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Halt wins over a full memory so a halt in the last slot still finishes cleanly.
          if (data_q == HALT_WORD) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (idx_q == IDXW'(MEM_DEPTH - 1)) begin
            state_d = ST_ERROR;
            ovf_d   = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_RECV;
          end
        end
        default: state_d = state_q;
      endcase
    end
    busy_d = (state_d == ST_RECV) || (state_d == ST_WRITE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_wr_en    = wr_en_q;
  assign o_wr_addr  = addr_q;
  assign o_wr_data  = data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - randomized and directed bench for inst_mem_loader
// A transaction-level model predicts every output each cycle; directed loads pin it with literals.
module tb_inst_mem_loader;

  localparam int          DEPTH = 4;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_byte_valid;
  logic [7:0]  i_byte;
  logic        o_byte_ready, o_wr_en, o_busy, o_done, o_overflow;
  logic [31:0] o_wr_addr, o_wr_data;

  inst_mem_loader #(.NBITS(32), .MEM_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_byte(i_byte),
    .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready), .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_busy(o_busy),
    .o_done(o_done), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a load is in progress, a write is due, bytes gathered so far, and the word slot.
  bit          m_loading, m_writing, m_done, m_ovf;
  int          m_slot;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_addr, m_data;
  logic [63:0] wlog[$];

  function automatic bit m_ready();
    return m_loading && !m_writing;
  endfunction

  task automatic model_step();
    if (!i_rst) begin
      m_loading = 0; m_writing = 0; m_done = 0; m_ovf = 0; m_slot = 0;
      m_bytes.delete(); m_addr = '0; m_data = '0;
    end else if (i_start) begin
      m_loading = 1; m_writing = 0; m_done = 0; m_ovf = 0; m_slot = 0;
      m_bytes.delete();
    end else if (m_writing) begin
      m_writing = 0;
      if (m_data == HALT) begin
        m_done = 1; m_loading = 0;
      end else if (m_slot == DEPTH - 1) begin
        m_ovf = 1; m_loading = 0;
      end else begin
        m_slot++;
      end
    end else if (m_loading && i_byte_valid) begin
      m_bytes.push_back(i_byte);
      if (m_bytes.size() == 4) begin
        m_data = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        m_addr = 32'(m_slot * 4);
        m_writing = 1;
        m_bytes.delete();
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("wr_en", 64'(o_wr_en), 64'(m_writing));
    chk("byte_ready", 64'(o_byte_ready), 64'(m_ready()));
    chk("busy", 64'(o_busy), 64'(m_loading));
    chk("done", 64'(o_done), 64'(m_done));
    chk("overflow", 64'(o_overflow), 64'(m_ovf));
    chk("wr_addr", 64'(o_wr_addr), 64'(m_addr));
    chk("wr_data", 64'(o_wr_data), 64'(m_data));
    if (o_wr_en) wlog.push_back({o_wr_addr, o_wr_data});
  end

  task automatic pulse_start();
    i_start = 1; i_byte_valid = 0;
    @(negedge clk);
    i_start = 0;
  endtask

  task automatic send_bytes(input logic [7:0] b[$], input int gap_pct);
    foreach (b[k]) begin
      bit acc = 0;
      int guard = 0;
      while (!acc) begin
        bit v   = ($urandom_range(99) >= gap_pct);
        bit rdy = m_ready();
        i_byte = v ? b[k] : 8'($urandom);
        i_byte_valid = v;
        @(negedge clk);
        acc = v && rdy;
        guard++;
        if (guard > 100) begin
          chk("byte_timeout", 64'(guard), 64'd0);
          i_byte_valid = 0;
          return;
        end
      end
    end
    i_byte_valid = 0;
  endtask

  task automatic send_words(input logic [31:0] w[$], input int gap_pct);
    logic [7:0] b[$];
    foreach (w[k]) for (int s = 3; s >= 0; s--) b.push_back(w[k][8*s +: 8]);
    send_bytes(b, gap_pct);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(o_done || o_overflow) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("end_timeout", 64'(n), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] prog[$];
    logic [7:0]  pb[$];
    i_rst = 0; i_start = 0; i_byte = '0; i_byte_valid = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {57'd0, o_byte_ready, o_wr_en, o_busy, o_done, o_overflow, 2'b00}, 64'd0);
    chk("reset_addr_data", {o_wr_addr, o_wr_data}, 64'd0);
    i_rst = 1;
    @(negedge clk);

    // Reset in the middle of a word.
    pulse_start();
    pb = '{8'h12, 8'h34};
    send_bytes(pb, 0);
    i_rst = 0;
    #1;
    chk("midreset_outs", {58'd0, o_byte_ready, o_wr_en, o_busy, o_done, o_overflow, 1'b0}, 64'd0);
    @(negedge clk);
    i_rst = 1;
    @(negedge clk);
    pulse_start();
    chk("start_busy", 64'(o_busy), 64'd1);
    chk("start_ready", 64'(o_byte_ready), 64'd1);

    // Two-word program, valid held high.
    wlog.delete();
    pb = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_bytes(pb, 0);
    wait_end();
    chk("dir_nwrites", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      chk("dir_write1", wlog[0], {32'h0, 32'h8C01_0004});
      chk("dir_write2", wlog[1], {32'h4, 32'hFFFF_FFFF});
    end
    chk("dir_done", 64'(o_done), 64'd1);
    chk("dir_busy", 64'(o_busy), 64'd0);

    // Gappy valid, byte held across the write cycle.
    pulse_start();
    wlog.delete();
    prog = '{32'hA1B2_C3D4, 32'h1234_5678, HALT};
    send_words(prog, 40);
    wait_end();
    chk("gap_nwrites", 64'(wlog.size()), 64'd3);
    if (wlog.size() == 3) begin
      chk("gap_write1", wlog[0], {32'h0, 32'hA1B2_C3D4});
      chk("gap_write2", wlog[1], {32'h4, 32'h1234_5678});
    end

    // Fill memory without a halt word.
    pulse_start();
    wlog.delete();
    prog = '{32'h1, 32'h2, 32'h3, 32'h4};
    send_words(prog, 0);
    wait_end();
    i_byte = 8'h55; i_byte_valid = 1;
    repeat (8) @(negedge clk);
    i_byte_valid = 0;
    chk("ovf_nwrites", 64'(wlog.size()), 64'd4);
    if (wlog.size() == 4) chk("ovf_write4", wlog[3], {32'hC, 32'h4});
    chk("ovf_flag", 64'(o_overflow), 64'd1);
    chk("ovf_done", 64'(o_done), 64'd0);

    // Halt word in the last slot.
    pulse_start();
    chk("restart_clears_ovf", 64'(o_overflow), 64'd0);
    wlog.delete();
    prog = '{32'h1, 32'h2, 32'h3, HALT};
    send_words(prog, 20);
    wait_end();
    if (wlog.size() == 4) chk("last_halt_write", wlog[3], {32'hC, HALT});
    chk("last_halt_done", 64'(o_done), 64'd1);
    chk("last_halt_ovf", 64'(o_overflow), 64'd0);

    // Restart after two bytes, with a valid byte in the start cycle.
    pulse_start();
    wlog.delete();
    pb = '{8'hDE, 8'hAD};
    send_bytes(pb, 0);
    i_start = 1; i_byte = 8'hAA; i_byte_valid = 1;
    @(negedge clk);
    i_start = 0; i_byte_valid = 0;
    prog = '{32'h1122_3344, HALT};
    send_words(prog, 0);
    wait_end();
    if (wlog.size() >= 1) chk("restart_write1", wlog[0], {32'h0, 32'h1122_3344});
    else chk("restart_nwrites", 64'(wlog.size()), 64'd2);

    // Random programs, occasionally interrupted by a restart part-way through.
    for (int t = 0; t < 40; t++) begin
      int  n;
      bit  has_halt;
      int  gap = $urandom_range(60);
      pulse_start();
      if ($urandom_range(3) == 0) begin
        pb.delete();
        for (int k = 0, m = $urandom_range(1, 9); k < m; k++) pb.push_back(8'($urandom));
        send_bytes(pb, gap);
        pulse_start();
      end
      wlog.delete();
      prog.delete();
      has_halt = $urandom_range(1);
      n = has_halt ? $urandom_range(1, DEPTH) : DEPTH;
      for (int k = 0; k < n; k++) begin
        logic [31:0] w = $urandom;
        if (w == HALT) w = 32'h0;
        prog.push_back((has_halt && k == n - 1) ? HALT : w);
      end
      send_words(prog, gap);
      wait_end();
      chk("rand_done", 64'(o_done), 64'(has_halt));
      chk("rand_ovf", 64'(o_overflow), 64'(!has_halt));
      chk("rand_nwrites", 64'(wlog.size()), 64'(n));
      foreach (wlog[k]) if (k < n) chk("rand_image", wlog[k], {32'(k * 4), prog[k]});
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Program loader for the instruction memory write port of the fetch stage. It accepts a byte stream from the debug/UART side over a valid/ready handshake and assembles the bytes into 32-bit words, MSB first. Each complete word is written to consecutive word-aligned byte addresses starting at 0. Loading ends when the halt word is written; the CPU then runs from PC 0.

## Interface
Parameters:
- NBITS, 32, instruction/address width
- MEM_DEPTH, 256, instruction memory capacity in words (power of two)
- HALT_WORD, 32'hFFFF_FFFF, end-of-program marker; it is written to memory like any other word

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-low reset (asserted when 0)
- i_start  in  1  begin a new load: clears address and byte count, enters RECV; honoured in every state
- i_byte  in  8  incoming program byte
- i_byte_valid  in  1  i_byte is valid this cycle
- o_byte_ready  out  1  loader accepts a byte this cycle
- o_wr_en  out  1  instruction memory write enable (1-cycle pulse per word)
- o_wr_addr  out  NBITS  byte address of the write (word_idx*4)
- o_wr_data  out  NBITS  assembled word
- o_busy  out  1  load in progress (RECV or WRITE)
- o_done  out  1  halt word has been written; level, held until i_start
- o_overflow  out  1  memory filled without a halt word; level, held until i_start

## Operation
- FSM states: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE: o_byte_ready=0. i_start → RECV with word_idx=0 and byte_cnt=0.
- RECV: o_byte_ready=1. A byte is accepted when i_byte_valid && o_byte_ready. Shift: word = {word[23:0], i_byte}, byte_cnt++.
- On acceptance of the 4th byte (byte_cnt==3): latch the full word into o_wr_data, set o_wr_addr = word_idx<<2, and go to WRITE.
- WRITE: exactly one cycle. o_wr_en=1, o_byte_ready=0. Next state:
  - word==HALT_WORD → DONE
  - else word_idx==MEM_DEPTH-1 → ERROR
  - else word_idx++ → RECV
- DONE / ERROR: o_byte_ready=0; stay in the state until i_start.
- i_start has priority over everything, including a byte arriving in the same cycle (that byte is dropped) and a pending WRITE (the write is suppressed; o_wr_en stays 0). After i_start the state is RECV with word_idx=0, byte_cnt=0, and o_done/o_overflow cleared.
- Bytes offered while not ready are not consumed. The sender holds them.
- A halt word in the last slot (word_idx==MEM_DEPTH-1) → DONE, not ERROR.
- o_busy=1 in RECV and WRITE.

## Timing
- All outputs are registered except o_byte_ready, which is decoded from state.
- Reset values: state=IDLE, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_done=0, o_overflow=0, o_byte_ready=0.
- Reset mid-load: immediate return to IDLE; partial word is discarded. Words already written are not erased.
- Latency: 4th byte accepted at edge N → o_wr_en high for the cycle after edge N → memory captures at edge N+1. o_done or o_overflow rises at edge N+1.
- Peak throughput: one word per 5 cycles (4 accept cycles + 1 write cycle).
- o_wr_addr and o_wr_data are stable for the whole o_wr_en cycle.

## Structure
- Shared package/header holds:
  - FSM state encoding (3 bits)
  - the HALT_WORD default
  - the BYTES_PER_WORD=4 constant, shared with the debug unit that streams programs
- One natural sub-module: byte_word_assembler. It contains the 32-bit shift register and 2-bit byte counter, with load/clear/full outputs.
- The FSM, word index counter (log2(MEM_DEPTH) bits), and output registers live in the top module.

## Test plan
- Reset with i_rst=0 mid-stream → all outputs 0, state IDLE. Release and pulse i_start → o_busy=1, o_byte_ready=1.
- Stream bytes 8C,01,00,04 then FF,FF,FF,FF with valid held high:
  - write 1: o_wr_en at addr 0x0, data 0x8C010004
  - write 2: o_wr_en at addr 0x4, data 0xFFFFFFFF
  - o_done=1 one cycle after write 2, o_busy=0
- Bytes with gaps in i_byte_valid, plus valid held high during the WRITE cycle → that byte is not consumed in WRITE and is accepted on the next RECV cycle. Word order and addresses are unchanged.
- MEM_DEPTH=4, four non-halt words 0x00000001..0x00000004:
  - writes at 0x0, 0x4, 0x8, 0xC
  - o_overflow=1 after the 4th write; no further o_wr_en
- Same depth with halt word as the 4th word → written at 0xC; o_done=1, o_overflow=0.
- i_start asserted after 2 bytes of a word, in the same cycle as a valid byte → byte dropped, byte_cnt=0. The next 4 bytes form a word written at addr 0x0.
